// File: rtl/intro_animator_pkg.sv
// intro_animator_pkg: shared state encoding, default constants and helpers for the intro sequence
package intro_animator_pkg;
  typedef enum logic [1:0] {ST_CLIMB, ST_RISE, ST_FALL, ST_DONE} state_t;
  localparam int Y_LAND_DEF    = 175;
  localparam int JUMP_H_DEF    = 32;
  localparam int CLIMB_DIV_DEF = 400_000;
  localparam int GRAV_DIV_DEF  = 1_000_000;
  localparam int DRIFT_DIV_DEF = 500_000;
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return &v ? v : v + 12'd1;
  endfunction
  function automatic logic [11:0] sat_dec(input logic [11:0] v);
    return v == '0 ? v : v - 12'd1;
  endfunction
endpackage

// File: rtl/intro_animator_tick_div.sv
// intro_animator_tick_div: enable-gated clock divider emitting a one-cycle tick every DIV enabled cycles
module intro_animator_tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] count;
  assign tick = en && count == W'(DIV - 1);
  // count enabled cycles, wrapping on tick; holds while disabled
  always_ff @(posedge clk)
    count <= (rst || clr || tick) ? '0 : en ? count + 1'b1 : count;
endmodule

// File: rtl/intro_animator.sv
// intro_animator: ladder climb then N hop cycles with drift, landing flags, rung count and done pulse
module intro_animator
  import intro_animator_pkg::*;
#(
  parameter int X_START    = 484,
  parameter int Y_START    = 672,
  parameter int Y_LAND     = Y_LAND_DEF,
  parameter int JUMP_H     = JUMP_H_DEF,
  parameter int N_JUMPS    = 4,
  parameter int CLIMB_DIV  = CLIMB_DIV_DEF,
  parameter int GRAV_DIV   = GRAV_DIV_DEF,
  parameter int DRIFT_DIV  = DRIFT_DIV_DEF,
  parameter bit DRIFT_LEFT = 1'b1,
  parameter int RUNG_STEP  = 32,
  parameter int RUNG_Y_MAX = 576,
  parameter int RUNG_MAX   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               skip,
  output logic               active,
  output logic               done,
  output logic [11:0]        xpos,
  output logic [11:0]        ypos,
  output logic [3:0]         rungs,
  output logic [N_JUMPS-1:0] landed
);
  localparam logic [11:0] LAND      = 12'(Y_LAND);
  localparam logic [11:0] APEX      = 12'(Y_LAND - JUMP_H);
  localparam logic [11:0] RUNG_MASK = 12'(RUNG_STEP - 1);
  localparam logic [11:0] RUNG_TOP  = 12'(RUNG_Y_MAX);
  localparam logic [3:0]  RUNG_SAT  = 4'(RUNG_MAX);
  state_t state, state_n;
  logic [11:0] vel, vel_n, xpos_n, ypos_n, y_dec;
  logic [4:0] hop, hop_n;
  logic [3:0] rungs_n;
  logic [N_JUMPS-1:0] landed_n;
  logic climb_tick, grav_tick, drift_tick, hopping, aborting, reach_apex, reach_land, enter_rise;
  logic signed [12:0] y_up;
  logic [12:0] y_down;
  assign hopping    = state == ST_RISE || state == ST_FALL;
  assign aborting   = skip && state != ST_DONE;
  assign y_dec      = ypos - 12'd1;
  assign y_up       = $signed({1'b0, ypos}) - $signed({1'b0, vel});
  assign y_down     = {1'b0, ypos} + {1'b0, vel};
  assign reach_apex = y_up <= $signed({1'b0, APEX});
  assign reach_land = y_down >= {1'b0, LAND};
  assign enter_rise = state == ST_CLIMB && state_n == ST_RISE;
  intro_animator_tick_div #(.DIV(CLIMB_DIV)) u_climb (
    .clk(clk), .rst(rst), .en(state == ST_CLIMB && start), .clr(1'b0), .tick(climb_tick)
  );
  intro_animator_tick_div #(.DIV(GRAV_DIV)) u_grav (
    .clk(clk), .rst(rst), .en(hopping), .clr(enter_rise), .tick(grav_tick)
  );
  intro_animator_tick_div #(.DIV(DRIFT_DIV)) u_drift (
    .clk(clk), .rst(rst), .en(hopping), .clr(enter_rise), .tick(drift_tick)
  );
  // state register
  always_ff @(posedge clk)
    state <= rst ? ST_CLIMB : state_n;
  // next state: skip overrides any transition triggered in the same cycle
  always_comb begin
    state_n = state;
    if (aborting)
      state_n = ST_DONE;
    else if (state == ST_CLIMB && (ypos <= LAND || (climb_tick && y_dec == LAND)))
      state_n = ST_RISE;
    else if (state == ST_RISE && grav_tick && reach_apex)
      state_n = ST_FALL;
    else if (state == ST_FALL && grav_tick && reach_land)
      state_n = hop + 5'd1 == 5'(N_JUMPS) ? ST_DONE : ST_RISE;
  end
  // next datapath values: climb/rung counting, ballistic hop with clamps, drift
  always_comb begin
    xpos_n   = xpos;
    ypos_n   = ypos;
    vel_n    = vel;
    hop_n    = hop;
    rungs_n  = rungs;
    landed_n = landed;
    if (aborting) begin
      ypos_n   = LAND;
      vel_n    = '0;
      landed_n = '1;
      rungs_n  = RUNG_SAT;
    end else begin
      if (state == ST_CLIMB && climb_tick && ypos > LAND) begin
        ypos_n  = y_dec;
        rungs_n = (y_dec <= RUNG_TOP && (y_dec & RUNG_MASK) == '0 && rungs < RUNG_SAT) ? rungs + 4'd1 : rungs;
      end
      if (enter_rise)
        vel_n = '0;
      if (state == ST_RISE && grav_tick) begin
        ypos_n = reach_apex ? APEX : ypos - vel;
        vel_n  = reach_apex ? '0 : sat_inc(vel);
      end
      if (state == ST_FALL && grav_tick) begin
        ypos_n   = reach_land ? LAND : ypos + vel;
        vel_n    = reach_land ? '0 : sat_inc(vel);
        landed_n = reach_land ? landed | (N_JUMPS'(1) << hop) : landed;
        hop_n    = reach_land ? hop + 5'd1 : hop;
      end
      if (hopping && drift_tick)
        xpos_n = DRIFT_LEFT ? sat_dec(xpos) : sat_inc(xpos);
    end
  end
  // registered outputs and counters; active falls on the edge done rises
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos   <= 12'(X_START);
      ypos   <= 12'(Y_START);
      vel    <= '0;
      hop    <= '0;
      rungs  <= '0;
      landed <= '0;
      active <= 1'b1;
      done   <= 1'b0;
    end else begin
      xpos   <= xpos_n;
      ypos   <= ypos_n;
      vel    <= vel_n;
      hop    <= hop_n;
      rungs  <= rungs_n;
      landed <= landed_n;
      active <= state_n != ST_DONE;
      done   <= state_n == ST_DONE && state != ST_DONE;
    end
  end
endmodule

// File: tb/tb_intro_animator.sv
// tb_intro_animator: directed self-checking bench for the intro climb/hop sequencer
module tb_intro_animator;
  logic clk = 1'b0, rst, start, skip, active, done;
  logic [11:0] xpos, ypos;
  logic [3:0] rungs;
  logic [1:0] landed;
  int errors = 0, checks = 0;
  int ys[16] = '{10, 9, 7, 5, 5, 6, 8, 10, 10, 9, 7, 5, 5, 6, 8, 10};
  always #5 clk = ~clk;
  intro_animator #(
    .X_START(100), .Y_START(40), .Y_LAND(10), .JUMP_H(5), .N_JUMPS(2),
    .CLIMB_DIV(2), .GRAV_DIV(1), .DRIFT_DIV(2), .DRIFT_LEFT(1'b1),
    .RUNG_STEP(8), .RUNG_Y_MAX(32), .RUNG_MAX(15)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .skip(skip), .active(active), .done(done),
    .xpos(xpos), .ypos(ypos), .rungs(rungs), .landed(landed)
  );
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, 32'(xpos), 100);
    chk({tag, "_y"}, 32'(ypos), 40);
    chk({tag, "_active"}, 32'(active), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rungs"}, 32'(rungs), 0);
    chk({tag, "_landed"}, 32'(landed), 0);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; skip = 1'b0;
    step(2);
    chk_reset("reset");
    rst = 1'b0; start = 1'b1;
    step(20);
    chk("climb_y30", 32'(ypos), 30);
    chk("climb_rung32", 32'(rungs), 1);
    start = 1'b0;
    step(20);
    chk("climb_hold", 32'(ypos), 30);
    start = 1'b1;
    step(39);
    chk("climb_y11", 32'(ypos), 11);
    chk("climb_active", 32'(active), 1);
    step(1);
    chk("climb_top", 32'(ypos), 10);
    chk("climb_rungs", 32'(rungs), 3);
    for (int e = 0; e < 16; e++) begin
      step(1);
      chk($sformatf("hop_y_e%0d", e + 1), 32'(ypos), 32'(ys[e]));
      chk($sformatf("hop_x_e%0d", e + 1), 32'(xpos), 32'(100 - (e + 1) / 2));
      chk($sformatf("hop_landed_e%0d", e + 1), 32'(landed), e >= 15 ? 3 : e >= 7 ? 1 : 0);
      chk($sformatf("hop_done_e%0d", e + 1), 32'(done), e == 15 ? 1 : 0);
      chk($sformatf("hop_active_e%0d", e + 1), 32'(active), e == 15 ? 0 : 1);
    end
    step(1);
    chk("done_pulse_end", 32'(done), 0);
    chk("done_hold_x", 32'(xpos), 92);
    chk("done_hold_y", 32'(ypos), 10);
    chk("done_rungs", 32'(rungs), 3);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    chk("skip_in_done", 32'(done), 0);
    chk("skip_in_done_rungs", 32'(rungs), 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reset("rst2");
    step(65);
    chk("fall_y", 32'(ypos), 5);
    chk("fall_x", 32'(xpos), 98);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    chk("skip_y", 32'(ypos), 10);
    chk("skip_x", 32'(xpos), 98);
    chk("skip_landed", 32'(landed), 3);
    chk("skip_rungs", 32'(rungs), 15);
    chk("skip_done", 32'(done), 1);
    chk("skip_active", 32'(active), 0);
    step(1);
    chk("skip_done_end", 32'(done), 0);
    skip = 1'b1;
    step(1);
    skip = 1'b0;
    chk("reskip_done", 32'(done), 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(65);
    chk("fall2_y", 32'(ypos), 5);
    rst = 1'b1; skip = 1'b1;
    step(1);
    rst = 1'b0; skip = 1'b0;
    chk_reset("rst_fall");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
